// File: rtl/noc_vc_merge_if.sv
// Flit handshake bundle shared by the two VC receive channels and the outgoing link.
// The master drives valid/flit/flags; the slave answers with ready.
interface noc_vc_merge_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] flit;
  logic                  is_header;
  logic                  is_tail;

  modport master (
    output valid,
    output flit,
    output is_header,
    output is_tail,
    input  ready
  );

  modport slave (
    input  valid,
    input  flit,
    input  is_header,
    input  is_tail,
    output ready
  );
endinterface

// File: rtl/noc_vc_merge.sv
// Two-VC transmit merge: per-VC flit FIFOs feeding one physical link through a
// packet-atomic round-robin arbiter that stays locked to a VC until its tail leaves.
module noc_vc_merge #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           noc_clk,
  input  logic           noc_rst_n,
  noc_vc_merge_if.slave  Noc_channel0_receive,
  noc_vc_merge_if.slave  Noc_channel1_receive,
  output logic           Noc_channel0_VCready,
  output logic           Noc_channel1_VCready,
  noc_vc_merge_if.master Noc_sender,
  output logic           Noc_sender_vc_id,
  output logic           Noc_merge_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int EW    = DATA_WIDTH + 2;   // {is_header, is_tail, flit}

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  // Registered state
  logic [EW-1:0]    r_mem    [2][FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr [2];
  logic [PTR_W-1:0] r_rd_ptr [2];
  logic [CNT_W-1:0] r_count  [2];
  state_t           r_state;
  logic             r_lock_vc;
  logic             r_last_grant;
  logic             r_err;

  // Combinational nets
  logic [1:0]    w_in_valid;
  logic [EW-1:0] w_in_entry [2];
  logic [1:0]    w_in_ready;
  logic [1:0]    w_push;
  logic [1:0]    w_pop;
  logic [1:0]    w_nempty;
  logic [EW-1:0] w_head     [2];
  logic [1:0]    w_head_tail;
  logic [1:0]    w_cand;
  logic [1:0]    w_bad;
  logic          w_grant_valid;
  logic          w_grant_vc;
  logic          w_out_valid;
  logic          w_out_fire;
  logic [EW-1:0] w_out_entry;

  assign w_in_valid[0] = Noc_channel0_receive.valid;
  assign w_in_valid[1] = Noc_channel1_receive.valid;
  assign w_in_entry[0] = {Noc_channel0_receive.is_header,
                          Noc_channel0_receive.is_tail,
                          Noc_channel0_receive.flit};
  assign w_in_entry[1] = {Noc_channel1_receive.is_header,
                          Noc_channel1_receive.is_tail,
                          Noc_channel1_receive.flit};

  assign Noc_channel0_receive.ready = w_in_ready[0];
  assign Noc_channel1_receive.ready = w_in_ready[1];
  assign Noc_channel0_VCready       = ~w_nempty[0];
  assign Noc_channel1_VCready       = ~w_nempty[1];

  // Per-VC FIFO status and arbitration candidates. Ready depends only on the
  // registered count, so a full FIFO refuses input even when it is popped.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_in_ready[i]  = (r_count[i] != CNT_MAX);
      w_push[i]      = w_in_valid[i] & w_in_ready[i];
      w_nempty[i]    = (r_count[i] != '0);
      w_head[i]      = r_mem[i][r_rd_ptr[i]];
      w_head_tail[i] = w_head[i][EW-2];
      w_cand[i]      = (r_state == S_IDLE) & w_nempty[i] &  w_head[i][EW-1];
      w_bad[i]       = (r_state == S_IDLE) & w_nempty[i] & ~w_head[i][EW-1];
    end
  end

  // With both VCs contending, the one that did not own the last packet wins.
  assign w_grant_valid = |w_cand;
  assign w_grant_vc    = (&w_cand) ? ~r_last_grant : w_cand[1];

  assign w_out_valid = (r_state == S_BUSY) & w_nempty[r_lock_vc];
  assign w_out_fire  = w_out_valid & Noc_sender.ready;

  // Pops: the locked VC on a link handshake while busy; while idle, one stray
  // non-header head is discarded per cycle, VC0 first.
  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    w_pop = '0;
    if (r_state == S_BUSY) begin
      w_pop[r_lock_vc] = w_out_fire;
    end else if (w_bad[0]) begin
      w_pop[0] = 1'b1;
    end else if (w_bad[1]) begin
      w_pop[1] = 1'b1;
    end
  end

  // NOTE: flit storage carries no reset; r_count gates every read, so stale entries are never seen.
  always_ff @(posedge noc_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wr_ptr[i]] <= w_in_entry[i];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_push[i]) begin
          r_wr_ptr[i] <= r_wr_ptr[i] + PTR_ONE;
        end
        if (w_pop[i]) begin
          r_rd_ptr[i] <= r_rd_ptr[i] + PTR_ONE;
        end
        case ({w_push[i], w_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + CNT_ONE;
          2'b01:   r_count[i] <= r_count[i] - CNT_ONE;
          default: r_count[i] <= r_count[i];
        endcase
      end
    end
  end

  // Link ownership: lock on grant, release after the tail flit handshakes.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      r_state      <= S_IDLE;
      r_lock_vc    <= 1'b0;
      r_last_grant <= 1'b1;
      r_err        <= 1'b0;
    end else begin
      if (|w_bad) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_grant_valid) begin
            r_lock_vc <= w_grant_vc;
            r_state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_out_fire && w_head_tail[r_lock_vc]) begin
            r_last_grant <= r_lock_vc;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sender fields are forced to zero whenever no flit is offered.
  assign w_out_entry          = w_out_valid ? w_head[r_lock_vc] : '0;
  assign Noc_sender.valid     = w_out_valid;
  assign Noc_sender.is_header = w_out_entry[EW-1];
  assign Noc_sender.is_tail   = w_out_entry[EW-2];
  assign Noc_sender.flit      = w_out_entry[DATA_WIDTH-1:0];
  assign Noc_sender_vc_id     = (r_state == S_BUSY) & r_lock_vc;
  assign Noc_merge_err        = r_err;

endmodule

// File: tb/tb_noc_vc_merge.sv
// Directed bench for noc_vc_merge: arbitration order, backpressure, mid-packet
// bubbles, stray body flits and reset mid-packet, with hand-computed expectations.
module tb_noc_vc_merge;

  logic noc_clk;
  logic noc_rst_n;
  logic vcready0;
  logic vcready1;
  logic sender_vc_id;
  logic merge_err;

  int n_tests = 0;
  int n_fail  = 0;

  noc_vc_merge_if #(.DATA_WIDTH(32)) ch0 ();
  noc_vc_merge_if #(.DATA_WIDTH(32)) ch1 ();
  noc_vc_merge_if #(.DATA_WIDTH(32)) snd ();

  noc_vc_merge #(
    .DATA_WIDTH(32),
    .FIFO_DEPTH(4)
  ) dut (
    .noc_clk              (noc_clk),
    .noc_rst_n            (noc_rst_n),
    .Noc_channel0_receive (ch0),
    .Noc_channel1_receive (ch1),
    .Noc_channel0_VCready (vcready0),
    .Noc_channel1_VCready (vcready1),
    .Noc_sender           (snd),
    .Noc_sender_vc_id     (sender_vc_id),
    .Noc_merge_err        (merge_err)
  );

  initial noc_clk = 1'b0;
  always #5 noc_clk = ~noc_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compares {valid, is_header, is_tail, vc_id, flit} in one step.
  task automatic chk_out(input string tag, input logic v, input logic h, input logic t,
                         input logic id, input logic [31:0] f);
    check(tag, {28'd0, snd.valid, snd.is_header, snd.is_tail, sender_vc_id, snd.flit},
               {28'd0, v, h, t, id, f});
  endtask

  task automatic drv(input int vc, input logic v, input logic [31:0] f,
                     input logic h, input logic t);
    if (vc == 0) begin
      ch0.valid = v; ch0.flit = f; ch0.is_header = h; ch0.is_tail = t;
    end else begin
      ch1.valid = v; ch1.flit = f; ch1.is_header = h; ch1.is_tail = t;
    end
  endtask

  task automatic tick();
    @(posedge noc_clk);
    #1;
  endtask

  initial begin
    drv(0, 1'b0, 32'h0, 1'b0, 1'b0);
    drv(1, 1'b0, 32'h0, 1'b0, 1'b0);
    snd.ready = 1'b1;
    noc_rst_n = 1'b0;
    repeat (2) @(posedge noc_clk);
    #1;

    // Reset state
    check("rst_vcready0", vcready0, 1'b1);
    check("rst_vcready1", vcready1, 1'b1);
    check("rst_ready0", ch0.ready, 1'b1);
    check("rst_ready1", ch1.ready, 1'b1);
    chk_out("rst_sender", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("rst_err", merge_err, 1'b0);
    noc_rst_n = 1'b1;

    // Contention after reset: VC0 first, one idle arbitration cycle, then VC1
    drv(0, 1'b1, 32'hB0, 1'b1, 1'b0);
    drv(1, 1'b1, 32'hC0, 1'b1, 1'b0);
    tick();
    chk_out("arb_idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    drv(0, 1'b1, 32'hB1, 1'b0, 1'b0);
    drv(1, 1'b1, 32'hC1, 1'b0, 1'b0);
    tick();
    chk_out("rr1_b0", 1'b1, 1'b1, 1'b0, 1'b0, 32'hB0);
    drv(0, 1'b1, 32'hB2, 1'b0, 1'b1);
    drv(1, 1'b1, 32'hC2, 1'b0, 1'b1);
    tick();
    drv(0, 1'b0, 32'h0, 1'b0, 1'b0);
    drv(1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_out("rr1_b1", 1'b1, 1'b0, 1'b0, 1'b0, 32'hB1);
    tick();
    chk_out("rr1_b2", 1'b1, 1'b0, 1'b1, 1'b0, 32'hB2);
    tick();
    chk_out("rr1_gap", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("rr1_vcready1_wait", vcready1, 1'b0);
    tick();
    chk_out("rr1_c0", 1'b1, 1'b1, 1'b0, 1'b1, 32'hC0);
    tick();
    chk_out("rr1_c1", 1'b1, 1'b0, 1'b0, 1'b1, 32'hC1);
    tick();
    chk_out("rr1_c2", 1'b1, 1'b0, 1'b1, 1'b1, 32'hC2);
    tick();
    chk_out("rr1_done", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("rr1_vcready0", vcready0, 1'b1);
    check("rr1_vcready1", vcready1, 1'b1);

    // Single VC0 packet: header two cycles after input, VCready0 drops then returns
    drv(0, 1'b1, 32'hA0, 1'b1, 1'b0);
    tick();
    check("single_vcready0_low", vcready0, 1'b0);
    chk_out("single_idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    drv(0, 1'b1, 32'hA1, 1'b0, 1'b0);
    tick();
    chk_out("single_a0", 1'b1, 1'b1, 1'b0, 1'b0, 32'hA0);
    drv(0, 1'b1, 32'hA2, 1'b0, 1'b1);
    tick();
    drv(0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_out("single_a1", 1'b1, 1'b0, 1'b0, 1'b0, 32'hA1);
    tick();
    chk_out("single_a2", 1'b1, 1'b0, 1'b1, 1'b0, 32'hA2);
    tick();
    chk_out("single_done", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("single_vcready0_high", vcready0, 1'b1);

    // Contention again: VC0 owned the last packet, so VC1 goes first
    drv(0, 1'b1, 32'hD0, 1'b1, 1'b0);
    drv(1, 1'b1, 32'hE0, 1'b1, 1'b0);
    tick();
    drv(0, 1'b1, 32'hD1, 1'b0, 1'b0);
    drv(1, 1'b1, 32'hE1, 1'b0, 1'b0);
    tick();
    chk_out("rr2_e0", 1'b1, 1'b1, 1'b0, 1'b1, 32'hE0);
    drv(0, 1'b1, 32'hD2, 1'b0, 1'b1);
    drv(1, 1'b1, 32'hE2, 1'b0, 1'b1);
    tick();
    drv(0, 1'b0, 32'h0, 1'b0, 1'b0);
    drv(1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_out("rr2_e1", 1'b1, 1'b0, 1'b0, 1'b1, 32'hE1);
    tick();
    chk_out("rr2_e2", 1'b1, 1'b0, 1'b1, 1'b1, 32'hE2);
    tick();
    chk_out("rr2_gap", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_out("rr2_d0", 1'b1, 1'b1, 1'b0, 1'b0, 32'hD0);
    tick();
    chk_out("rr2_d1", 1'b1, 1'b0, 1'b0, 1'b0, 32'hD1);
    tick();
    chk_out("rr2_d2", 1'b1, 1'b0, 1'b1, 1'b0, 32'hD2);
    tick();
    chk_out("rr2_done", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Backpressure: VC1 five-flit packet into a depth-4 FIFO with the link stalled
    snd.ready = 1'b0;
    drv(1, 1'b1, 32'hF0, 1'b1, 1'b0);
    tick();
    check("bp_ready1_open", ch1.ready, 1'b1);
    drv(1, 1'b1, 32'hF1, 1'b0, 1'b0);
    tick();
    chk_out("bp_f0_offer", 1'b1, 1'b1, 1'b0, 1'b1, 32'hF0);
    drv(1, 1'b1, 32'hF2, 1'b0, 1'b0);
    tick();
    drv(1, 1'b1, 32'hF3, 1'b0, 1'b0);
    tick();
    drv(1, 1'b1, 32'hF4, 1'b0, 1'b1);
    check("bp_full_after_4", ch1.ready, 1'b0);
    chk_out("bp_f0_held1", 1'b1, 1'b1, 1'b0, 1'b1, 32'hF0);
    tick();
    check("bp_still_full", ch1.ready, 1'b0);
    chk_out("bp_f0_held2", 1'b1, 1'b1, 1'b0, 1'b1, 32'hF0);
    snd.ready = 1'b1;
    tick();
    check("bp_no_bypass", ch1.ready, 1'b1);
    chk_out("bp_f1", 1'b1, 1'b0, 1'b0, 1'b1, 32'hF1);
    tick();
    drv(1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_out("bp_f2", 1'b1, 1'b0, 1'b0, 1'b1, 32'hF2);
    tick();
    chk_out("bp_f3", 1'b1, 1'b0, 1'b0, 1'b1, 32'hF3);
    tick();
    chk_out("bp_f4", 1'b1, 1'b0, 1'b1, 1'b1, 32'hF4);
    tick();
    chk_out("bp_done", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("bp_vcready1", vcready1, 1'b1);

    // Mid-packet input gap on VC0 while VC1 holds a waiting header
    drv(0, 1'b1, 32'h60, 1'b1, 1'b0);
    drv(1, 1'b1, 32'h70, 1'b1, 1'b0);
    tick();
    drv(0, 1'b1, 32'h61, 1'b0, 1'b0);
    drv(1, 1'b1, 32'h71, 1'b0, 1'b1);
    tick();
    drv(0, 1'b0, 32'h0, 1'b0, 1'b0);
    drv(1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_out("gap_g0", 1'b1, 1'b1, 1'b0, 1'b0, 32'h60);
    tick();
    chk_out("gap_g1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h61);
    tick();
    chk_out("gap_bubble1", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_out("gap_bubble2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    drv(0, 1'b1, 32'h62, 1'b0, 1'b0);
    tick();
    drv(0, 1'b1, 32'h63, 1'b0, 1'b1);
    chk_out("gap_g2", 1'b1, 1'b0, 1'b0, 1'b0, 32'h62);
    tick();
    drv(0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_out("gap_g3", 1'b1, 1'b0, 1'b1, 1'b0, 32'h63);
    tick();
    chk_out("gap_arb", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_out("gap_j0", 1'b1, 1'b1, 1'b0, 1'b1, 32'h70);
    tick();
    chk_out("gap_j1", 1'b1, 1'b0, 1'b1, 1'b1, 32'h71);
    tick();
    chk_out("gap_done", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Stray body flit on VC1 while idle: discarded, error sticks
    drv(1, 1'b1, 32'hBAD, 1'b0, 1'b0);
    tick();
    drv(1, 1'b0, 32'h0, 1'b0, 1'b0);
    check("err_not_yet", merge_err, 1'b0);
    chk_out("err_idle1", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check("err_set", merge_err, 1'b1);
    check("err_vcready1", vcready1, 1'b1);
    chk_out("err_idle2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    drv(1, 1'b1, 32'h77, 1'b1, 1'b1);
    tick();
    drv(1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_out("err_idle3", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_out("err_next_pkt", 1'b1, 1'b1, 1'b1, 1'b1, 32'h77);
    tick();
    chk_out("err_next_done", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("err_sticky", merge_err, 1'b1);

    // Reset after the header of a 4-flit VC0 packet has left
    drv(0, 1'b1, 32'h90, 1'b1, 1'b0);
    tick();
    drv(0, 1'b1, 32'h91, 1'b0, 1'b0);
    tick();
    drv(0, 1'b1, 32'h92, 1'b0, 1'b0);
    chk_out("mr_h", 1'b1, 1'b1, 1'b0, 1'b0, 32'h90);
    tick();
    drv(0, 1'b1, 32'h93, 1'b0, 1'b1);
    chk_out("mr_b1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h91);
    noc_rst_n = 1'b0;
    #1;
    chk_out("mr_rst_sender", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("mr_rst_vcready0", vcready0, 1'b1);
    check("mr_rst_ready0", ch0.ready, 1'b1);
    check("mr_rst_err", merge_err, 1'b0);
    drv(0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    noc_rst_n = 1'b1;
    drv(0, 1'b1, 32'h55, 1'b1, 1'b1);
    tick();
    drv(0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("mr_vcready0_busy", vcready0, 1'b0);
    tick();
    chk_out("mr_55", 1'b1, 1'b1, 1'b1, 1'b0, 32'h55);
    tick();
    chk_out("mr_done", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("mr_vcready0_free", vcready0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_vc_merge.md
Name: noc_vc_merge

Overview:
- Transmit-side counterpart of the VC allocator: collects the two virtual-channel flit streams and serialises them onto one physical link.
- Each VC has its own flit FIFO and raises a VCready flag whenever it can take a new packet.
- Packet-atomic round-robin arbitration: once a header is granted, the link stays locked to that VC until its tail flit leaves.
- Sits between the VC buffers of a router input port and the outgoing link, or the next router's receive port.

Parameters:
- DATA_WIDTH, 32: flit width; equals Noc_Data_Width.
- FIFO_DEPTH, 4: entries per VC FIFO; power of two, at least 2.

Ports:
- noc_clk  in  1  single clock, rising edge.
- noc_rst_n  in  1  asynchronous active-low reset.
- Noc_channel0_receive_valid  in  1  VC0 flit valid.
- Noc_channel0_receive_ready  out  1  VC0 FIFO not full.
- Noc_channel0_receive_flit  in  DATA_WIDTH  VC0 flit.
- Noc_channel0_receive_is_header  in  1  VC0 flit is header.
- Noc_channel0_receive_is_tail  in  1  VC0 flit is tail.
- Noc_channel0_VCready  out  1  VC0 FIFO empty; new packet may be started.
- Noc_channel1_receive_valid, _ready, _flit, _is_header, _is_tail, Noc_channel1_VCready: same as VC0, for VC1.
- Noc_sender_valid  out  1  output flit valid.
- Noc_sender_ready  in  1  downstream accepts.
- Noc_sender_flit  out  DATA_WIDTH  output flit.
- Noc_sender_is_header  out  1  output header flag.
- Noc_sender_is_tail  out  1  output tail flag.
- Noc_sender_vc_id  out  1  VC currently owning the link.
- Noc_merge_err  out  1  sticky protocol error.

Behaviour:
- Reset (async, active-low):
  - FIFOs empty (count 0, pointers 0); state IDLE; last_grant = 1, so VC0 wins first.
  - VCready = 1; receive_ready = 1; all sender outputs 0; Noc_merge_err = 0.
- FIFO per VC:
  - Entry holds {is_header, is_tail, flit}.
  - Push on valid & ready; pop on the output handshake of the owning VC.
  - receive_ready = (count != FIFO_DEPTH). No bypass: a full FIFO refuses input even if a pop happens in the same cycle.
  - Simultaneous push and pop leaves count unchanged. Pointers wrap modulo FIFO_DEPTH.
  - VCready = (count == 0), combinational from registered count.
- State IDLE:
  - Candidate VCx has a non-empty FIFO with is_header = 1 at its head.
  - One candidate: it is granted. Two candidates: grant the VC != last_grant.
  - On grant, register lock_vc and move to BUSY next cycle. Arbitration costs one cycle.
  - Head flit without is_header: pop and discard it (VC0 checked before VC1, one pop per cycle), set Noc_merge_err. Stay IDLE.
- State BUSY:
  - Noc_sender_valid = FIFO[lock_vc] non-empty.
  - flit, is_header, is_tail = FIFO[lock_vc] head when valid, else 0.
  - Noc_sender_vc_id = lock_vc.
  - Pop on Noc_sender_valid & Noc_sender_ready. If the popped flit has is_tail: last_grant <= lock_vc, return to IDLE.
  - Header plus tail in one flit (single-flit packet) ends the packet.
  - The other VC is never served mid-packet, even while the locked FIFO is empty (bubbles allowed).
  - Outputs are held stable while valid & !ready.
- Latency: flit accepted at cycle t sits at FIFO head at t+1. A header can appear on the sender at t+2 at the earliest. Body flits stream one per cycle at full throughput.
- In IDLE, Noc_sender_valid = 0 and all sender data outputs are 0.
- Noc_merge_err clears only on reset.
- Reset mid-packet: everything returns to reset values immediately; partial packets are dropped.

Test Plan:
- Single packet on VC0, flits 0xA0(H), 0xA1, 0xA2(T), sender_ready = 1 → sender emits the three flits on consecutive cycles, header 2 cycles after input, vc_id = 0. VCready0 drops to 0 while data is buffered and returns to 1 once drained.
- Both VCs load a 3-flit packet in the same cycle → VC0 packet sent fully first, then VC1 after one idle arbitration cycle. Repeat → VC1 then VC0 (round robin).
- sender_ready held 0 with VC1 sending 5 flits, DEPTH = 4 → VC1 receive_ready = 0 after 4 accepts. Release ready → all 5 flits delivered in order, none lost.
- VC0 packet with a 3-cycle input gap mid-packet while VC1 holds a waiting header → no VC1 flit appears until the VC0 tail has been sent.
- VC1 sends a body flit (no header) while IDLE → flit never appears on sender; Noc_merge_err = 1 and stays 1. A following valid packet passes normally.
- Assert reset after the header of a 4-flit packet has been sent → all outputs 0 and VCready = 1 during reset. After release, a new single-flit H/T packet (0x55) is delivered correctly.
